// File: rtl/de4_qsys_pio_pkg.sv
// Shared register map for the DE4 Qsys parallel I/O blocks (button input and
// LED output). Both blocks decode the same 2-bit Avalon-MM word address.
package de4_qsys_pio_pkg;

    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

    // Width of the counter that has to reach cycles-1 without wrapping.
    function automatic int count_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/de4_qsys_debounce.sv
// One-bit 2-flop synchroniser followed by a stable-cycle debouncer.
// The debounced level only follows the synchronised pin after it has
// differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
module de4_qsys_debounce
    import de4_qsys_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level
);

    localparam int                CNT_W   = count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= RESET_VAL;
            sync_q    <= RESET_VAL;
        end else begin
            sync_meta <= pin;
            sync_q    <= sync_meta;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    // The counter never exceeds CNT_MAX, so it cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= RESET_VAL;
        end else if (sync_q == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            level <= sync_q;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/de4_qsys_button_in.sv
// Avalon-MM push-button input port: per-pin synchronise and debounce,
// falling-edge capture with write-1-to-clear, masked level interrupt.
module de4_qsys_button_in
    import de4_qsys_pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] debounced_prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_clear;
    logic             write_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        de4_qsys_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_LEVEL[i])
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .level   (debounced[i])
        );
    end

    assign write_en   = chipselect & ~write_n;
    assign fall       = debounced_prev & ~debounced;
    assign edge_clear = (write_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Previous debounced value; reset to RESET_LEVEL so reset release is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced_prev <= RESET_LEVEL;
        end else begin
            debounced_prev <= debounced;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (write_en && address == ADDR_MASK) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Falling-edge capture; a new edge wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clear) | fall;
        end
    end

    // Combinational read mux; reads have no side effects.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = debounced;
            ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
            default:   readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: doc/de4_qsys_button_in.md
DE4_QSYS_BUTTON_IN -- requirements
Module: de4_qsys_button_in

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of input pins.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles needed to accept a pin change; legal range 2..2^20.
REQ-003 SHALL have parameter RESET_LEVEL, default all ones, reset value of the synchroniser and debounced state (buttons released).
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port reset_n, input, 1, reset (asynchronous, active-low).
REQ-006 SHALL have port address, input, 2, Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port readdata, output, 32, read data; bits above WIDTH are zero.
REQ-011 SHALL have port in_port, input, WIDTH, asynchronous external pins (active-low buttons).
REQ-012 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-013 SHALL pass in_port through a 2-flop synchroniser per bit before any other use.
REQ-014 SHALL debounce each bit independently: a per-bit counter clears whenever the synchronised bit equals the debounced bit; otherwise it increments, and the debounced bit takes the synchronised value on the cycle the counter reaches DEBOUNCE_CYCLES-1, clearing the counter.
REQ-015 SHALL make a pin glitch shorter than DEBOUNCE_CYCLES cycles produce no change in the debounced state.
REQ-016 SHALL set edge_capture[i] on the cycle after debounced[i] goes 1->0 (falling edge only).
REQ-017 SHALL decode the register map with zero wait states and combinational readdata: 0 = debounced (RO), 1 = reserved (reads 0, writes ignored), 2 = irq_mask (RW, WIDTH bits), 3 = edge_capture (read; write-1-to-clear).
REQ-018 SHALL complete a write when chipselect=1 and write_n=0; writes to address 0 or 1 have no effect.
REQ-019 SHALL keep an edge_capture bit set when a write-1-to-clear and a new falling edge on that bit occur in the same cycle.
REQ-020 SHALL drive irq = OR of (edge_capture AND irq_mask), combinational from registers, so irq changes in the cycle after the causing register update.
REQ-021 SHALL have no read side effects.

Reset
REQ-022 SHALL asynchronously set synchroniser flops and debounced state to RESET_LEVEL, and counters, irq_mask and edge_capture to 0, on reset_n low.
REQ-023 SHALL drive irq=0 and readdata equal to the reset register contents while reset_n is low.
REQ-024 SHALL generate no edge_capture set on reset release when in_port already equals RESET_LEVEL.
REQ-025 SHALL abandon any in-progress debounce count on reset mid-operation, with no partial state surviving.

Structure
REQ-026 SHALL take register address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3) from shared package de4_qsys_pio_pkg, which the LED output block also uses.
REQ-027 SHALL implement synchroniser plus debounce counter for one bit as sub-module de4_qsys_debounce, instantiated WIDTH times by generate.
REQ-028 SHALL size each debounce counter as clog2(DEBOUNCE_CYCLES) bits; wrap-around is impossible by construction.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4)
REQ-029 SHALL cover reset: assert reset_n low with in_port=8'hFF, release -> read addr0=32'h000000FF, addr2=0, addr3=0, irq=0.
REQ-030 SHALL cover press: in_port[2] low for 10 cycles -> addr0 reads 8'hFB within 2+4+1 cycles; addr3 reads 8'h04; irq stays 0 while mask=0.
REQ-031 SHALL cover glitch: in_port[5] low for 3 cycles then high -> addr0 stays 8'hFF and addr3 stays 0.
REQ-032 SHALL cover interrupt: write addr2=8'h04 after the press -> irq=1 next cycle; write addr3=8'h04 -> irq=0 and addr3=0 next cycle.
REQ-033 SHALL cover simultaneous clear and edge: write-1-to-clear on addr3 bit 0 in the same cycle as debounced[0] falls -> addr3 bit 0 reads 1 afterwards.
REQ-034 SHALL cover reset mid-count: pulse reset_n low after 2 of 4 stable low cycles on in_port[0] -> after release, debounced[0]=1 until 4 further full stable low cycles.
